// File: rtl/mersenne_pkg.sv
// Shared types and constants for the Mersenne datapath blocks
// (serial multiplier and divisibility checker).
package mersenne_pkg;

    localparam int NUMBER_LENGTH = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the serial multiplier.
interface serial_multiplier_if
    import mersenne_pkg::*;
#(
    parameter int N = NUMBER_LENGTH
);

    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/serial_multiplier_bit_serial_adder.sv
// One-bit full adder with a registered carry; sum is combinational from x, y and carry.
module bit_serial_adder (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    input  logic y,
    output logic sum
);

    logic carry;

    assign sum = x ^ y ^ carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= (x & y) | (x & carry) | (y & carry);
        end
    end

endmodule

// File: rtl/serial_multiplier.sv
// Bit-serial shift-and-add multiplier: one product bit per cycle for every set
// multiplier bit, driven through a start/busy/done handshake.
module serial_multiplier
    import mersenne_pkg::*;
#(
    parameter int N = NUMBER_LENGTH
)
(
    input  logic               clk,
    input  logic               rst_n,
    serial_multiplier_if.slave bus
);

    localparam int MW = $clog2(N);
    localparam int BW = $clog2(2 * N);
    localparam logic [MW-1:0] MBIT_LAST = MW'(N - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(2 * N - 1);

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] product_r;
    logic [MW-1:0]  mbit;
    logic [BW-1:0]  bidx;
    logic [BW-1:0]  a_off;
    logic           sa;
    logic           sb;
    logic           sum;
    logic           accept;
    logic           add_clr;
    logic           add_en;
    logic           mbit_inc;

    bit_serial_adder u_adder (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (add_clr),
        .en    (add_en),
        .x     (sa),
        .y     (sb),
        .sum   (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        add_clr    = 1'b0;
        add_en     = 1'b0;
        mbit_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (b_r[mbit]) begin
                    add_clr    = 1'b1;
                    state_next = S_ADD;
                end else if (mbit == MBIT_LAST) begin
                    state_next = S_DONE;
                end else begin
                    mbit_inc = 1'b1;
                end
            end
            S_ADD: begin
                add_en = 1'b1;
                if (bidx == BIDX_LAST) begin
                    if (mbit == MBIT_LAST) begin
                        state_next = S_DONE;
                    end else begin
                        mbit_inc   = 1'b1;
                        state_next = S_CHECK;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Multiplicand bit aligned to the current product bit: a_r shifted left by mbit.
    always_comb begin
        a_off = bidx - BW'(mbit);
        sb    = 1'b0;
        if (bidx >= BW'(mbit)) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (a_off == BW'(i)) begin
                    sb = a_r[i];
                end
            end
        end
        sa       = acc[bidx];
        acc_next = acc;
        if (add_en) begin
            acc_next[bidx] = sum;
        end
    end

    // Product is taken from acc_next so the final sum bit lands in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            mbit      <= '0;
            bidx      <= '0;
            product_r <= '0;
        end else begin
            if (accept) begin
                a_r  <= bus.a;
                b_r  <= bus.b;
                acc  <= '0;
                mbit <= '0;
            end else begin
                acc <= acc_next;
                if (mbit_inc) begin
                    mbit <= mbit + MW'(1);
                end
            end
            if (add_clr) begin
                bidx <= '0;
            end else if (add_en && bidx != BIDX_LAST) begin
                bidx <= bidx + BW'(1);
            end
            if (state_next == S_DONE) begin
                product_r <= acc_next;
            end
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
    assign bus.product = product_r;

endmodule

// File: tb/tb_serial_multiplier.sv
// Directed and randomised checks of serial_multiplier results, latency and handshake.
module tb_serial_multiplier;

    localparam int N     = 9;
    localparam int LIMIT = 200;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_multiplier_if #(.N(N)) bus ();

    serial_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one op and returns the cycle of the first done plus the count of done
    // cycles seen up to one cycle after it; ends in an idle cycle.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int done_cyc, output int done_cnt);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_cyc  = 0;
        done_cnt  = 0;
        for (int c = 1; c <= LIMIT; c++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            tick();
            if (done_cyc != 0 && c > done_cyc) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        checks++;
        if (bus.product !== 18'd0) begin
            errors++;
            $display("FAIL reset_product: got %0d want 0", bus.product);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int busy_bad  = 0;
        int dcnt      = 0;
        int dcyc      = 0;
        logic busy155 = 1'bx;
        bus.a     = 9'd14;
        bus.b     = 9'd503;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            if (c <= 154 && bus.busy !== 1'b1) busy_bad++;
            if (c == 155) busy155 = bus.busy;
            if (bus.done === 1'b1) begin
                dcnt++;
                if (dcyc == 0) dcyc = c;
            end
            tick();
        end
        checks++;
        if (bus.product !== 18'd7042) begin
            errors++;
            $display("FAIL basic_product: got %0d want 7042", bus.product);
        end
        checks++;
        if (dcyc != 154) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 154", dcyc);
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL basic_done_width: got %0d want 1", dcnt);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL basic_busy_window: got %0d low cycles want 0", busy_bad);
        end
        checks++;
        if (busy155 !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_after: got %b want 0", busy155);
        end
    endtask

    task automatic test_max();
        int dcyc;
        int dcnt;
        run_op(9'h1FF, 9'h1FF, dcyc, dcnt);
        checks++;
        if (bus.product !== 18'h3FC01) begin
            errors++;
            $display("FAIL max_product: got %0h want 3fc01", bus.product);
        end
        checks++;
        if (dcyc != 172) begin
            errors++;
            $display("FAIL max_latency: got %0d want 172", dcyc);
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL max_done_width: got %0d want 1", dcnt);
        end
    endtask

    task automatic test_zero();
        int dcyc;
        int dcnt;
        run_op(9'd123, 9'd0, dcyc, dcnt);
        checks++;
        if (bus.product !== 18'd0) begin
            errors++;
            $display("FAIL zero_b_product: got %0d want 0", bus.product);
        end
        checks++;
        if (dcyc != 10) begin
            errors++;
            $display("FAIL zero_b_latency: got %0d want 10", dcyc);
        end
        // Seed a non-zero product so the following zero result is observable.
        run_op(9'd2, 9'd2, dcyc, dcnt);
        run_op(9'd0, 9'h1FF, dcyc, dcnt);
        checks++;
        if (bus.product !== 18'd0) begin
            errors++;
            $display("FAIL zero_a_product: got %0d want 0", bus.product);
        end
        checks++;
        if (dcyc != 172) begin
            errors++;
            $display("FAIL zero_a_latency: got %0d want 172", dcyc);
        end
    endtask

    task automatic test_start_ignored();
        int dcnt = 0;
        int d1   = 0;
        int d2   = 0;
        logic [2*N-1:0] p156 = '0;
        bus.a     = 9'd14;
        bus.b     = 9'd503;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 215; c++) begin
            bus.start = (c == 5 || c == 154 || c == 155);
            if (bus.start) begin
                bus.a = 9'd3;
                bus.b = 9'd3;
            end
            if (bus.done === 1'b1) begin
                dcnt++;
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
            if (c == 156) p156 = bus.product;
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (d1 != 154) begin
            errors++;
            $display("FAIL ignore_first_done: got %0d want 154", d1);
        end
        checks++;
        if (p156 !== 18'd7042) begin
            errors++;
            $display("FAIL ignore_product_held: got %0d want 7042", p156);
        end
        checks++;
        if (d2 != 201) begin
            errors++;
            $display("FAIL ignore_second_done: got %0d want 201", d2);
        end
        checks++;
        if (dcnt != 2) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d want 2", dcnt);
        end
        checks++;
        if (bus.product !== 18'd9) begin
            errors++;
            $display("FAIL ignore_second_product: got %0d want 9", bus.product);
        end
    endtask

    task automatic test_reset_abort();
        int   dcyc;
        int   dcnt;
        logic busy50 = 1'b0;
        bus.a     = 9'd14;
        bus.b     = 9'd503;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 50) begin
                busy50 = bus.busy;
                rst_n  = 1'b0;
            end
            tick();
        end
        rst_n = 1'b1;
        checks++;
        if (busy50 !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b->%b want 1->0", busy50, bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: got %b want 0", bus.done);
        end
        checks++;
        if (bus.product !== 18'd0) begin
            errors++;
            $display("FAIL abort_product: got %0d want 0", bus.product);
        end
        run_op(9'd5, 9'd7, dcyc, dcnt);
        checks++;
        if (bus.product !== 18'd35) begin
            errors++;
            $display("FAIL abort_next_product: got %0d want 35", bus.product);
        end
        checks++;
        if (dcyc != 64) begin
            errors++;
            $display("FAIL abort_next_latency: got %0d want 64", dcyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] ea;
        logic [2*N-1:0] eb;
        logic [2*N-1:0] exp_p;
        int dcyc;
        int exp_lat;
        int dones = 0;
        for (int op = 0; op < 200; op++) begin
            ea        = {{N{1'b0}}, N'($urandom_range(0, 511))};
            eb        = {{N{1'b0}}, N'($urandom_range(0, 511))};
            exp_p     = ea * eb;
            exp_lat   = 1 + N + $countones(eb) * 2 * N;
            bus.a     = ea[N-1:0];
            bus.b     = eb[N-1:0];
            bus.start = 1'b1;
            tick();
            bus.a = N'($urandom);
            bus.b = N'($urandom);
            dcyc  = 0;
            for (int c = 1; c <= LIMIT && dcyc == 0; c++) begin
                if (bus.done === 1'b1) dcyc = c;
                else tick();
            end
            if (dcyc != 0) dones++;
            checks++;
            if (bus.product !== exp_p) begin
                errors++;
                $display("FAIL b2b_product op %0d: %0d*%0d got %0d want %0d",
                         op, ea, eb, bus.product, exp_p);
            end
            checks++;
            if (dcyc != exp_lat) begin
                errors++;
                $display("FAIL b2b_latency op %0d: got %0d want %0d", op, dcyc, exp_lat);
            end
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle op %0d: done=%b busy=%b want 0 0",
                         op, bus.done, bus.busy);
            end
        end
        bus.start = 1'b0;
        tick();
        checks++;
        if (dones != 200) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d want 200", dones);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
